rom_sequencer: RTL and testbench
================================

ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
- REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the ROM address width.
- REQ-002 The block SHALL have parameter DATA_W, default 34, meaning the ROM word width.
- REQ-003 The block SHALL have parameter LAST_ADDR, default 63, meaning the final address of the program.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-006 The block SHALL have port start, input, 1 bit: begin a program run.
- REQ-007 The block SHALL have port rom_addr, output, ADDR_W bits: address driven to the combinational ROM; equals pc.
- REQ-008 The block SHALL have port rom_data, input, DATA_W bits: ROM word at rom_addr, same cycle.
- REQ-009 The block SHALL have port instr, output, DATA_W bits: registered fetched word.
- REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr holds a word.
- REQ-011 The block SHALL have port instr_ready, input, 1 bit: consumer accepts instr this cycle.
- REQ-012 The block SHALL have port branch_en, input, 1 bit: redirect, sampled only on an accepting cycle.
- REQ-013 The block SHALL have port branch_target, input, ADDR_W bits: next pc when branch_en is sampled.
- REQ-014 The block SHALL have port busy, output, 1 bit: high in FETCH or HOLD.
- REQ-015 The block SHALL have port done, output, 1 bit: high in DONE.

Function
- REQ-016 The FSM SHALL have states IDLE, FETCH, HOLD, DONE.
- REQ-017 In IDLE or DONE, start=1 SHALL set pc<=0, clear done and go to FETCH; start SHALL be ignored in FETCH and HOLD.
- REQ-018 FETCH SHALL last exactly one cycle: instr<=rom_data, instr_valid<=1, then HOLD.
- REQ-019 HOLD SHALL keep instr and instr_valid stable until instr_valid and instr_ready are both high (accept).
- REQ-020 On accept, instr_valid<=0; if branch_en, pc<=branch_target and go to FETCH; else if pc==LAST_ADDR or the halt condition holds, go to DONE with pc unchanged; else pc<=pc+1 and go to FETCH.
- REQ-021 Branch SHALL take precedence over both end-of-program and halt.
- REQ-022 pc+1 SHALL wrap modulo 2^ADDR_W; this is reachable only when LAST_ADDR is not the maximum address and a branch places pc above LAST_ADDR.
- REQ-023 Steady-state throughput SHALL be one word per 2 cycles with instr_ready held high; first instr_valid SHALL appear 2 cycles after start is sampled.

Reset
- REQ-024 With rst=1 at a clock edge, the block SHALL set state=IDLE, pc=0, instr=0, instr_valid=0, busy=0, done=0, in any state including mid-HOLD; rst SHALL override start.

Configuration
- REQ-025 With ROM_SEQ_HALT_EN defined, an accepted word equal to all zeros SHALL be a halt condition (REQ-020).
- REQ-026 Without ROM_SEQ_HALT_EN, words SHALL never be inspected and only LAST_ADDR SHALL end a run.

Structure
- REQ-027 Package rom_seq_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the HALT_WORD constant (all zeros).
- REQ-028 Sub-module rom_seq_pc SHALL hold the pc register with load-zero, load-target and increment controls; the FSM stays in rom_sequencer.

Verification
- REQ-029 Linear run: ROM word[k]=k+1, LAST_ADDR=3, ready=1, pulse start -> instr 1,2,3,4 on cycles 2,4,6,8 after start; done=1 after word 4; rom_addr holds 3.
- REQ-030 Backpressure: ready=0 for 5 cycles in HOLD on word 0 -> instr stays 1, valid stays 1, rom_addr stays 0; accepted on the first ready cycle.
- REQ-031 Branch: branch_en=1 and target=5 on accept of word 1 -> next instr = word[5]; branch at pc==LAST_ADDR -> fetch continues, no done.
- REQ-032 Halt (ROM_SEQ_HALT_EN defined): word[2]=0 -> done after accepting address 2; with the macro undefined, the run continues to LAST_ADDR.
- REQ-033 Reset mid-run: rst in HOLD at pc=4 -> next cycle state=IDLE, pc=0, valid=0; start in HOLD is ignored; start in DONE restarts at address 0.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared types and defaults for the ROM-driven instruction sequencer.
package rom_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 34;

  // Word value that ends a run when the halt feature is built in.
  localparam logic [DATA_W_DEF-1:0] HALT_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage : rom_seq_pkg

// File: rtl/rom_seq_pc.sv
// Program counter for the ROM sequencer: load-zero, load-target and
// increment controls, in that priority order. Increment wraps naturally.
module rom_seq_pc
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_zero_i,
  input  logic              load_target_i,
  input  logic              incr_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (load_zero_i) begin
      pc_q <= '0;
    end else if (load_target_i) begin
      pc_q <= target_i;
    end else if (incr_i) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc_o = pc_q;

endmodule : rom_seq_pc

// File: rtl/rom_sequencer.sv
// ROM sequencer: fetches words from a combinational ROM one at a time and
// presents each on a valid/ready handshake, with branch redirect on accept.
// Optional feature macro: ROM_SEQ_HALT_EN -- an accepted all-zero word ends
// the run just like reaching LAST_ADDR.
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned LAST_ADDR = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] pc;

  logic accept_c;
  logic halt_c;
  logic end_c;
  logic load_zero_c;
  logic load_target_c;
  logic incr_c;

  // Handshake, end-of-run detection and pc controls for this cycle.
  always_comb begin
    accept_c = (state_q == ST_HOLD) && instr_valid_q && instr_ready;
`ifdef ROM_SEQ_HALT_EN
    halt_c   = (instr_q == DATA_W'(HALT_WORD));
`else
    halt_c   = 1'b0;
`endif
    end_c         = (pc == ADDR_W'(LAST_ADDR)) || halt_c;
    load_zero_c   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    load_target_c = accept_c && branch_en;
    incr_c        = accept_c && !branch_en && !end_c;
  end

  rom_seq_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .load_zero_i  (load_zero_c),
    .load_target_i(load_target_c),
    .incr_i       (incr_c),
    .target_i     (branch_target),
    .pc_o         (pc)
  );

  // Sequencer FSM with registered instr/valid/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          instr_q       <= rom_data;
          instr_valid_q <= 1'b1;
          state_q       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (accept_c) begin
            instr_valid_q <= 1'b0;
            if (branch_en || !end_c) begin
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = pc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : rom_sequencer

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: small 8-entry ROM, LAST_ADDR=3, so a
// branch above LAST_ADDR exercises the pc wrap back to 0.
module tb_rom_sequencer;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 34;
  localparam int unsigned LAST   = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rom [8];

  int tests_run = 0;
  int tests_failed = 0;

  rom_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LAST_ADDR(LAST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .busy         (busy),
    .done         (done)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = DATA_W'(i + 1);
    rst = 1'b1; start = 1'b0; instr_ready = 1'b1;
    branch_en = 1'b0; branch_target = '0;
    #2;

    // Reset, with start asserted to show reset wins.
    start = 1'b1;
    step(); step();
    start = 1'b0;
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_busy",  64'(busy),        64'(0));
    check("rst_done",  64'(done),        64'(0));
    check("rst_addr",  64'(rom_addr),    64'(0));
    check("rst_instr", 64'(instr),       64'(0));
    rst = 1'b0;

    // Linear run: words 1..4 on cycles 2,4,6,8 after start.
    start = 1'b1;
    step();
    start = 1'b0;
    check("lin_fetch_busy",  64'(busy),        64'(1));
    check("lin_fetch_valid", 64'(instr_valid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("lin_valid%0d", k), 64'(instr_valid), 64'(1));
      check($sformatf("lin_instr%0d", k), 64'(instr),       64'(k + 1));
      check($sformatf("lin_addr%0d", k),  64'(rom_addr),    64'(k));
      step();
      if (k < 3) check($sformatf("lin_acc%0d", k), 64'(instr_valid), 64'(0));
    end
    check("lin_done",  64'(done),     64'(1));
    check("lin_busy",  64'(busy),     64'(0));
    check("lin_addr3", 64'(rom_addr), 64'(3));
    step();
    check("lin_done_hold", 64'(done), 64'(1));

    // Backpressure on word 0, start during HOLD ignored; restart from DONE.
    instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("bp_restart_done", 64'(done),     64'(0));
    check("bp_restart_addr", 64'(rom_addr), 64'(0));
    step();
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      check($sformatf("bp_instr%0d", c), 64'(instr),       64'(1));
      check($sformatf("bp_valid%0d", c), 64'(instr_valid), 64'(1));
      check($sformatf("bp_addr%0d", c),  64'(rom_addr),    64'(0));
    end
    start = 1'b0;
    instr_ready = 1'b1;
    step();
    check("bp_accept_valid", 64'(instr_valid), 64'(0));
    check("bp_accept_addr",  64'(rom_addr),    64'(1));
    step();
    check("bp_next_instr", 64'(instr), 64'(2));

    // Branch to 5 on accept of word 1, then 6,7, wrap to 0..3, done.
    branch_en = 1'b1; branch_target = 3'd5;
    step();
    branch_en = 1'b0;
    check("br_addr", 64'(rom_addr), 64'(5));
    step();
    check("br_instr", 64'(instr), 64'(6));
    for (int a = 6; a < 10; a++) begin
      step(); step();
      check($sformatf("br_walk_addr%0d", a % 8),  64'(rom_addr), 64'(a % 8));
      check($sformatf("br_walk_instr%0d", a % 8), 64'(instr),    64'((a % 8) + 1));
    end
    check("br_wrap_notdone", 64'(done), 64'(0));
    for (int a = 2; a < 4; a++) begin
      step(); step();
      check($sformatf("br_tail_instr%0d", a), 64'(instr), 64'(a + 1));
    end
    step();
    check("br_done", 64'(done), 64'(1));

    // Branch while at LAST_ADDR keeps fetching.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int a = 0; a < 3; a++) begin
      step(); step();
    end
    check("blast_addr",  64'(rom_addr), 64'(3));
    check("blast_instr", 64'(instr),    64'(4));
    branch_en = 1'b1; branch_target = 3'd1;
    step();
    branch_en = 1'b0;
    check("blast_done", 64'(done),     64'(0));
    check("blast_busy", 64'(busy),     64'(1));
    check("blast_addr1", 64'(rom_addr), 64'(1));
    step();
    check("blast_instr2", 64'(instr), 64'(2));

    // Reset in HOLD at pc=4.
    branch_en = 1'b1; branch_target = 3'd4;
    step();
    branch_en = 1'b0;
    step();
    check("mid_addr4",  64'(rom_addr),    64'(4));
    check("mid_instr5", 64'(instr),       64'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(instr_valid), 64'(0));
    check("mid_rst_addr",  64'(rom_addr),    64'(0));
    check("mid_rst_busy",  64'(busy),        64'(0));
    check("mid_rst_instr", 64'(instr),       64'(0));

    // Zero word at address 2: halts only when the feature is built in.
    rom[2] = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step(); step();
    step(); step();
    check("halt_instr0", 64'(instr),    64'(0));
    check("halt_addr2",  64'(rom_addr), 64'(2));
    step();
`ifdef ROM_SEQ_HALT_EN
    check("halt_done", 64'(done),     64'(1));
    check("halt_addr", 64'(rom_addr), 64'(2));
`else
    check("nohalt_done", 64'(done),     64'(0));
    check("nohalt_addr", 64'(rom_addr), 64'(3));
    step();
    check("nohalt_instr4", 64'(instr), 64'(4));
    step();
    check("nohalt_done_end", 64'(done), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rom_sequencer
